// File: rtl/musicbox_play_ctrl.sv
// musicbox_play_ctrl: playback sequencer and 1 Hz clock generator for the music box
//
// Ports:
//   clk        system clock
//   RESET      asynchronous reset, active-high
//   play_btn   debounced one-cycle pulse, toggles play/pause
//   next_btn   debounced one-cycle pulse, switches song
//   clk_1hz    50% square wave with a period of CLK_HZ cycles
//   tick_1s    one-cycle pulse in the cycle clk_1hz rises
//   song_sel   0 = song 1, 1 = song 2
//   sound_off  1 = muted/paused
//   play_secs  seconds played in the current song
//   song_end   one-cycle pulse after the current song reaches its length
//   state      STOP=00, PLAY=01, PAUSE=10, SWITCH=11
//
// Build option: define MUSICBOX_AUTO_ADVANCE_EN to move on to the other song at
// end of song; otherwise the current song loops.
module musicbox_play_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SONG1_LEN = 90,
    parameter int SONG2_LEN = 120
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        play_btn,
    input  logic        next_btn,
    output logic        clk_1hz,
    output logic        tick_1s,
    output logic        song_sel,
    output logic        sound_off,
    output logic [11:0] play_secs,
    output logic        song_end,
    output logic [1:0]  state
);
    localparam int DW = $clog2(CLK_HZ);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_HZ / 2);
    localparam logic [11:0] LAST1 = 12'(SONG1_LEN - 1);
    localparam logic [11:0] LAST2 = 12'(SONG2_LEN - 1);
`ifdef MUSICBOX_AUTO_ADVANCE_EN
    localparam bit AUTO_ADVANCE = 1'b1;
`else
    localparam bit AUTO_ADVANCE = 1'b0;
`endif
    typedef enum logic [1:0] {STOP = 2'b00, PLAY = 2'b01, PAUSE = 2'b10, SWITCH = 2'b11} state_t;
    state_t state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [11:0] play_secs_q, play_secs_d;
    logic clk_1hz_q, clk_1hz_d, tick_1s_q, tick_1s_d, song_sel_q, song_sel_d;
    logic sound_off_q, sound_off_d, song_end_q, song_end_d;
    logic song_done, toggle;
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= STOP;
            div_q       <= '0;
            play_secs_q <= '0;
            clk_1hz_q   <= 1'b0;
            tick_1s_q   <= 1'b0;
            song_sel_q  <= 1'b0;
            sound_off_q <= 1'b1;
            song_end_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            play_secs_q <= play_secs_d;
            clk_1hz_q   <= clk_1hz_d;
            tick_1s_q   <= tick_1s_d;
            song_sel_q  <= song_sel_d;
            sound_off_q <= sound_off_d;
            song_end_q  <= song_end_d;
        end
    end
    // next_btn outranks end of song, which outranks play_btn
    always_comb begin
        song_done = state_q == PLAY && tick_1s_q && play_secs_q == (song_sel_q ? LAST2 : LAST1);
        state_d   = state_q;
        case (state_q)
            STOP:    state_d = (!next_btn && play_btn) ? PLAY : STOP;
            PLAY:    state_d = next_btn ? SWITCH :
                               song_done ? (AUTO_ADVANCE ? SWITCH : PLAY) :
                               play_btn ? PAUSE : PLAY;
            PAUSE:   state_d = (!next_btn && play_btn) ? PLAY : PAUSE;
            default: state_d = PLAY;
        endcase
    end
    // Outputs are computed from the next state so the registered values line up with it;
    // the song toggles on entry to SWITCH, and buttons seen while in SWITCH are dropped.
    always_comb begin
        div_d       = div_q == DIV_LAST ? '0 : div_q + 1'b1;
        clk_1hz_d   = div_d >= DIV_HALF;
        tick_1s_d   = div_d == DIV_HALF;
        sound_off_d = state_d != PLAY;
        song_end_d  = song_done && !next_btn;
        toggle      = state_q != SWITCH && (next_btn || state_d == SWITCH);
        song_sel_d  = song_sel_q ^ toggle;
        play_secs_d = (toggle || song_done) ? 12'd0 :
                      (state_q == PLAY && tick_1s_q) ? play_secs_q + 12'd1 : play_secs_q;
    end
    assign state     = state_q;
    assign clk_1hz   = clk_1hz_q;
    assign tick_1s   = tick_1s_q;
    assign song_sel  = song_sel_q;
    assign sound_off = sound_off_q;
    assign play_secs = play_secs_q;
    assign song_end  = song_end_q;
endmodule
